rr_arb16: RTL and testbench

RR_ARB16 -- requirements
Module: rr_arb16

---
 rtl/arb_pkg.sv | 31 +++
 rtl/grant_dec4to16.sv | 17 +
 rtl/rr_arb16.sv | 85 ++++++++
 tb/tb_rr_arb16.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared widths, state encoding and round-robin pick for rr_arb16
package arb_pkg;

    localparam int NREQ   = 16;
    localparam int IDX_W  = 4;
    localparam int HCNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request scanning ptr, ptr+1, ... with the 4-bit index wrapping naturally.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + i[IDX_W-1:0];
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grant_dec4to16.sv
// rtl/grant_dec4to16.sv - 4-bit index plus enable to 16-bit one-hot decode
module grant_dec4to16
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREQ-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - 16-way round-robin arbiter with bounded grant hold time
module rr_arb16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [HCNT_W-1:0]  hcnt, hcnt_n;
    logic [IDX_W-1:0]   idx_n;
    logic               busy_n;
    logic               timeout_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            hcnt    <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            hcnt    <= hcnt_n;
            gnt_idx <= idx_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hcnt_n    = hcnt;
        idx_n     = gnt_idx;
        busy_n    = busy;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (en && (|req)) begin
                    state_n = GRANT;
                    idx_n   = rr_pick(req, ptr);
                    busy_n  = 1'b1;
                    hcnt_n  = '0;
                end
            end
            GRANT: begin
                // en is deliberately ignored here: an active grant is never revoked by it.
                if (!req[gnt_idx] || (hcnt == HOLD_LAST)) begin
                    state_n   = IDLE;
                    ptr_n     = gnt_idx + 1'b1;
                    idx_n     = '0;
                    busy_n    = 1'b0;
                    hcnt_n    = '0;
                    timeout_n = req[gnt_idx];
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    grant_dec4to16 u_dec (
        .idx    (gnt_idx),
        .en     (busy),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - self-checking bench for rr_arb16 against a cycle model
module tb_rr_arb16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] req;

    logic [15:0] gnt8, gnt1;
    logic [3:0]  idx8, idx1;
    logic        busy8, busy1, to8, to1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arb16 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .busy(busy8), .timeout(to8)
    );

    rr_arb16 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt1), .gnt_idx(idx1), .busy(busy1), .timeout(to1)
    );

    // Model: owner index (-1 = none), cycles shown so far, scan start, timeout flag.
    int m_own[2];
    int m_held[2];
    int m_start[2];
    bit m_to[2];
    bit m_valid = 1'b0;
    int lim[2] = '{8, 1};

    always @(posedge clk) begin
        int c;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_own[d]   = -1;
                m_held[d]  = 0;
                m_start[d] = 0;
                m_to[d]    = 1'b0;
            end else if (m_own[d] < 0) begin
                m_to[d] = 1'b0;
                if (en && req != 16'h0) begin
                    for (int i = 0; i < 16; i++) begin
                        c = (m_start[d] + i) % 16;
                        if (m_own[d] < 0 && req[c]) begin
                            m_own[d]  = c;
                            m_held[d] = 1;
                        end
                    end
                end
            end else if (!req[m_own[d]]) begin
                m_start[d] = (m_own[d] + 1) % 16;
                m_own[d]   = -1;
                m_to[d]    = 1'b0;
            end else if (m_held[d] == lim[d]) begin
                m_start[d] = (m_own[d] + 1) % 16;
                m_own[d]   = -1;
                m_to[d]    = 1'b1;
            end else begin
                m_held[d] = m_held[d] + 1;
            end
        end
        if (rst) m_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_gnt(input int d);
        logic [15:0] one;
        one = 16'h1;
        return (m_own[d] < 0) ? 16'h0 : (one << m_own[d]);
    endfunction

    function automatic logic [3:0] exp_idx(input int d);
        return (m_own[d] < 0) ? 4'd0 : 4'(m_own[d]);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m8_gnt",  {16'h0, gnt8},  {16'h0, exp_gnt(0)});
            chk("m8_idx",  {28'h0, idx8},  {28'h0, exp_idx(0)});
            chk("m8_busy", {31'h0, busy8}, {31'h0, m_own[0] >= 0});
            chk("m8_to",   {31'h0, to8},   {31'h0, m_to[0]});
            chk("m1_gnt",  {16'h0, gnt1},  {16'h0, exp_gnt(1)});
            chk("m1_idx",  {28'h0, idx1},  {28'h0, exp_idx(1)});
            chk("m1_busy", {31'h0, busy1}, {31'h0, m_own[1] >= 0});
            chk("m1_to",   {31'h0, to1},   {31'h0, m_to[1]});
            chk("onehot8", $countones(gnt8) <= 1, 1);
        end
    end

    task automatic step(input logic e, input logic [15:0] r);
        en  = e;
        req = r;
        @(negedge clk);
    endtask

    logic [16:0] table_v [16] = '{
        17'h1_0300, 17'h1_0300, 17'h1_0200, 17'h0_0000, 17'h1_A5A5, 17'h1_A5A5,
        17'h1_A5A4, 17'h0_FFFF, 17'h1_0008, 17'h1_8008, 17'h1_8000, 17'h1_0000,
        17'h1_1111, 17'h1_1110, 17'h1_0110, 17'h1_0000
    };

    initial begin
        logic [15:0] one;
        one = 16'h1;
        rst = 1'b1;
        en  = 1'b0;
        req = 16'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",  {16'h0, gnt8}, 32'h0);
        chk("rst_idx",  {28'h0, idx8}, 32'h0);
        chk("rst_busy", {31'h0, busy8}, 32'h0);
        chk("rst_to",   {31'h0, to8},  32'h0);
        rst = 1'b0;

        // Single requester held three cycles, then dropped; ptr lands on 5.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0010);
            chk("r4_gnt", {16'h0, gnt8}, 32'h0010);
            chk("r4_idx", {28'h0, idx8}, 32'd4);
        end
        step(1'b1, 16'h0000);
        chk("r4_rel", {16'h0, gnt8}, 32'h0);
        step(1'b1, 16'h0021);
        chk("ptr5_idx", {28'h0, idx8}, 32'd5);
        step(1'b1, 16'h0000);

        // Forced release after eight cycles of a held request.
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 16'h0001);
            if (i <= 8) chk("hold_gnt", {16'h0, gnt8}, 32'h0001);
            if (i == 9) begin
                chk("hold_idle", {16'h0, gnt8}, 32'h0);
                chk("hold_to",   {31'h0, to8},  32'h1);
            end
            if (i == 10) begin
                chk("hold_regnt", {16'h0, gnt8}, 32'h0001);
                chk("hold_to0",   {31'h0, to8},  32'h0);
            end
        end
        step(1'b1, 16'h0000);

        // Pointer wrap from 15 to 0.
        step(1'b1, 16'h4000);
        chk("g14_idx", {28'h0, idx8}, 32'd14);
        step(1'b1, 16'h0000);
        step(1'b1, 16'h8001);
        chk("wrap15_idx", {28'h0, idx8}, 32'd15);
        step(1'b1, 16'h0001);
        chk("wrap_idle", {16'h0, gnt8}, 32'h0);
        step(1'b1, 16'h0001);
        chk("wrap0_gnt", {16'h0, gnt8}, 32'h0001);
        step(1'b1, 16'h0000);

        // Reset in the middle of a grant to requester 7.
        step(1'b1, 16'h0080);
        chk("g7_idx", {28'h0, idx8}, 32'd7);
        step(1'b1, 16'h0080);
        rst = 1'b1;
        step(1'b1, 16'h0080);
        chk("mrst_gnt",  {16'h0, gnt8}, 32'h0);
        chk("mrst_idx",  {28'h0, idx8}, 32'h0);
        chk("mrst_busy", {31'h0, busy8}, 32'h0);
        chk("mrst_gnt1", {16'h0, gnt1}, 32'h0);
        rst = 1'b0;
        step(1'b1, 16'h0081);
        chk("prst_gnt", {16'h0, gnt8}, 32'h0001);
        step(1'b1, 16'h0000);

        // en blocks new grants but never revokes a live one.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0004);
            chk("en0_gnt", {16'h0, gnt8}, 32'h0);
        end
        step(1'b1, 16'h0004);
        chk("en1_gnt", {16'h0, gnt8}, 32'h0004);
        step(1'b0, 16'h0004);
        chk("en0_hold", {16'h0, gnt8}, 32'h0004);
        step(1'b1, 16'h0006);
        chk("other_bits", {16'h0, gnt8}, 32'h0004);
        step(1'b1, 16'h0002);
        chk("drop_rel", {16'h0, gnt8}, 32'h0);
        step(1'b1, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            step(table_v[i][16], table_v[i][15:0]);
        end

        // MAX_HOLD=1 with all requesting: strict rotation with timeouts between.
        rst = 1'b1;
        step(1'b0, 16'h0000);
        rst = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            step(1'b1, 16'hFFFF);
            chk("rot_idx",  {28'h0, idx1}, k % 16);
            chk("rot_gnt",  {16'h0, gnt1}, {16'h0, one << (k % 16)});
            step(1'b1, 16'hFFFF);
            chk("rot_idle", {16'h0, gnt1}, 32'h0);
            chk("rot_to",   {31'h0, to1},  32'h1);
        end
        step(1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
